coin_score_display: RTL

Parametrised successor to the fixed two-player coin path into the seven-segment interface. Holds one BCD coin counter per player and time-multiplexes every counter digit onto a shared active-low seven-segment bus. Supports N players × D digits, saturation, global clear and per-player leading-zero blanking. Sits between the game/draw logic (coin pulses in) and the board segment pins. Runs in the 25 MHz pixel-clock domain.

---
 rtl/coin_score_display.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/coin_score_display.sv
// Per-player BCD coin counters, time-multiplexed onto one active-low seven-segment bus.
// Each counter counts coin rising edges and saturates at all 9s. Every digit of every
// counter is lit in turn for REFRESH_DIV cycles. Leading zeros can optionally be blanked.
module coin_score_display #(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned REFRESH_DIV = 25000
) (
    input  logic                          Master_Clock_In,
    input  logic                          Reset_N_In,
    input  logic [N_PLAYERS-1:0]          Coin_Inc_In,
    input  logic                          Coin_Clr_In,
    input  logic                          Blank_Lead_In,
    output logic [N_PLAYERS*4*DIGITS-1:0] Coin_Value_Out,
    output logic [N_PLAYERS-1:0]          Saturated_Out,
    output logic [6:0]                    Seg_Out,
    output logic [N_PLAYERS*DIGITS-1:0]   An_Out
);

    localparam int unsigned FieldW = 4 * DIGITS;
    localparam int unsigned NumDig = N_PLAYERS * DIGITS;
    localparam int unsigned IdxW   = (NumDig > 1) ? $clog2(NumDig) : 1;
    localparam int unsigned DivW   = $clog2(REFRESH_DIV);
    localparam logic [FieldW-1:0] AllNines = {DIGITS{4'h9}};

    logic [N_PLAYERS-1:0]          prev_q, prev_d;
    logic [N_PLAYERS*FieldW-1:0]   cnt_q, cnt_d;
    logic [N_PLAYERS-1:0]          sat_q, sat_d;
    logic [DivW-1:0]               div_q, div_d;
    logic [IdxW-1:0]               idx_q, idx_d;
    logic [NumDig-1:0]             an_q, an_d;
    logic [6:0]                    seg_q, seg_d;

    // BCD ripple increment; a 9 wraps to 0 and carries upward.
    function automatic logic [FieldW-1:0] bcd_inc(input logic [FieldW-1:0] v);
        logic [FieldW-1:0] r;
        logic              carry;
        r     = v;
        carry = 1'b1;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (carry) begin
                if (r[j*4 +: 4] == 4'd9) begin
                    r[j*4 +: 4] = 4'd0;
                end else begin
                    r[j*4 +: 4] = r[j*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes show blank.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Coin edge detection and counter update; clear wins over an increment.
    always_comb begin
        logic [FieldW-1:0] field;
        field  = '0;
        cnt_d  = cnt_q;
        sat_d  = sat_q;
        prev_d = Coin_Inc_In;
        for (int p = 0; p < int'(N_PLAYERS); p++) begin
            field = cnt_q[p*FieldW +: FieldW];
            if (Coin_Clr_In) begin
                field = '0;
            end else if (Coin_Inc_In[p] && !prev_q[p] && (field != AllNines)) begin
                field = bcd_inc(field);
            end
            cnt_d[p*FieldW +: FieldW] = field;
            sat_d[p]                  = (field == AllNines);
        end
    end

    // Refresh divider and scan index advance.
    always_comb begin
        div_d = div_q + DivW'(1);
        idx_d = idx_q;
        if (div_q == DivW'(REFRESH_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == IdxW'(NumDig - 1)) ? '0 : idx_q + IdxW'(1);
        end
    end

    // Digit selection and leading-zero blanking for the current scan index.
    always_comb begin
        logic [3:0] digit;
        logic       upper_zero;
        logic       blank_dig;
        digit      = 4'd0;
        upper_zero = 1'b0;
        blank_dig  = 1'b0;
        for (int k = 0; k < int'(NumDig); k++) begin
            if (idx_q == IdxW'(k)) begin
                // Packed layout puts scan digit k at nibble k.
                digit      = cnt_q[k*4 +: 4];
                upper_zero = 1'b1;
                for (int m = k % int'(DIGITS); m < int'(DIGITS); m++) begin
                    if (cnt_q[((k / int'(DIGITS)) * int'(DIGITS) + m)*4 +: 4] != 4'd0) begin
                        upper_zero = 1'b0;
                    end
                end
                blank_dig = Blank_Lead_In && ((k % int'(DIGITS)) != 0) && upper_zero;
            end
        end
        seg_d = blank_dig ? 7'b1111111 : seg_encode(digit);
        an_d  = ~(NumDig'(1) << idx_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Master_Clock_In) begin
        if (!Reset_N_In) begin
            prev_q <= '0;
            cnt_q  <= '0;
            sat_q  <= '0;
            div_q  <= '0;
            idx_q  <= '0;
            an_q   <= '1;
            seg_q  <= 7'b1111111;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign Coin_Value_Out = cnt_q;
    assign Saturated_Out  = sat_q;
    assign Seg_Out        = seg_q;
    assign An_Out         = an_q;

endmodule
